// File: rtl/pd_motor_mixer_pkg.sv
// Shared types and constants for the PD motor mixer.
// States, widths and the captured term bundle.
package pd_mixer_pkg;

  localparam int SPD_W   = 11;
  localparam int SUM_W   = 14;
  localparam int PTERM_W = 10;
  localparam int DTERM_W = 12;
  localparam int THR_W   = 9;

  localparam logic [SPD_W-1:0] MIN_RUN_DEF = 11'd420;
  localparam logic [SPD_W-1:0] CAL_SPD_DEF = 11'd432;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t FRNT = 3'd1;
  localparam state_t BCK  = 3'd2;
  localparam state_t LFT  = 3'd3;
  localparam state_t RGHT = 3'd4;
  localparam state_t DONE = 3'd5;

  typedef struct packed {
    logic               cal;
    logic [THR_W-1:0]   thrst;
    logic [PTERM_W-1:0] ptch_p;
    logic [PTERM_W-1:0] roll_p;
    logic [PTERM_W-1:0] yaw_p;
    logic [DTERM_W-1:0] ptch_d;
    logic [DTERM_W-1:0] roll_d;
    logic [DTERM_W-1:0] yaw_d;
  } terms_t;

endpackage

// File: rtl/pd_motor_mixer_if.sv
// PD term producer to motor mixer / ESC bundle.
// master = term producer, slave = mixer.
interface pd_motor_mixer_if;
  import pd_mixer_pkg::*;

  logic               vld_in;
  logic [THR_W-1:0]   thrst;
  logic               inertial_cal;
  logic [PTERM_W-1:0] ptch_pterm;
  logic [PTERM_W-1:0] roll_pterm;
  logic [PTERM_W-1:0] yaw_pterm;
  logic [DTERM_W-1:0] ptch_dterm;
  logic [DTERM_W-1:0] roll_dterm;
  logic [DTERM_W-1:0] yaw_dterm;
  logic [SPD_W-1:0]   frnt_spd;
  logic [SPD_W-1:0]   bck_spd;
  logic [SPD_W-1:0]   lft_spd;
  logic [SPD_W-1:0]   rght_spd;
  logic               spd_vld;
  logic               busy;
  logic               ovrrun;

  modport master (
    output vld_in, thrst, inertial_cal,
    output ptch_pterm, roll_pterm, yaw_pterm,
    output ptch_dterm, roll_dterm, yaw_dterm,
    input  frnt_spd, bck_spd, lft_spd, rght_spd,
    input  spd_vld, busy, ovrrun
  );

  modport slave (
    input  vld_in, thrst, inertial_cal,
    input  ptch_pterm, roll_pterm, yaw_pterm,
    input  ptch_dterm, roll_dterm, yaw_dterm,
    output frnt_spd, bck_spd, lft_spd, rght_spd,
    output spd_vld, busy, ovrrun
  );

endinterface

// File: rtl/pd_motor_mixer_sat.sv
// Clamp a 14-bit signed mix result to an 11-bit
// unsigned motor speed.
module spd_sat
  import pd_mixer_pkg::*;
(
  input  logic [SUM_W-1:0] sum,
  output logic [SPD_W-1:0] spd
);

  always_comb begin
    spd = sum[SPD_W-1:0];
    if (sum[SUM_W-1])
      spd = '0;
    else if (|sum[SUM_W-2:SPD_W])
      spd = '1;
  end

endmodule

// File: rtl/pd_motor_mixer.sv
// Four-motor PD mixer: one shared adder/clamp walked
// across the motors by a small FSM, with a 1-deep pending slot.
module pd_motor_mixer
  import pd_mixer_pkg::*;
#(
  parameter logic [SPD_W-1:0] MIN_RUN = MIN_RUN_DEF,
  parameter logic [SPD_W-1:0] CAL_SPD = CAL_SPD_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  pd_motor_mixer_if.slave  mix
);

  state_t state, nxt;
  terms_t in_t, work, pend;
  logic   pend_vld;
  logic [SPD_W-1:0] sh_f, sh_b, sh_l, sh_r;
  logic [SPD_W-1:0] sat, mot;
  logic [SUM_W-1:0] pp, pr, py, base, ax, sum;
  logic neg_ax, neg_yaw;

  assign in_t = '{
    cal:    mix.inertial_cal,
    thrst:  mix.thrst,
    ptch_p: mix.ptch_pterm,
    roll_p: mix.roll_pterm,
    yaw_p:  mix.yaw_pterm,
    ptch_d: mix.ptch_dterm,
    roll_d: mix.roll_dterm,
    yaw_d:  mix.yaw_dterm
  };

  assign mix.busy = (state != IDLE);

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = mix.vld_in ? FRNT : IDLE;
      FRNT:    nxt = BCK;
      BCK:     nxt = LFT;
      LFT:     nxt = RGHT;
      RGHT:    nxt = DONE;
      DONE:    nxt = (pend_vld | mix.vld_in) ? FRNT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign pp = {{4{work.ptch_p[PTERM_W-1]}}, work.ptch_p}
            + {{2{work.ptch_d[DTERM_W-1]}}, work.ptch_d};
  assign pr = {{4{work.roll_p[PTERM_W-1]}}, work.roll_p}
            + {{2{work.roll_d[DTERM_W-1]}}, work.roll_d};
  assign py = {{4{work.yaw_p[PTERM_W-1]}}, work.yaw_p}
            + {{2{work.yaw_d[DTERM_W-1]}}, work.yaw_d};
  assign base = {3'b0, MIN_RUN} + {5'b0, work.thrst};

  // Pitch drives front/back, roll drives left/right
  always_comb begin
    ax      = pr;
    neg_ax  = 1'b0;
    neg_yaw = 1'b0;
    unique case (1'b1)
      state == FRNT: begin ax = pp; neg_yaw = 1'b1; end
      state == BCK:  begin
        ax = pp; neg_ax = 1'b1; neg_yaw = 1'b1;
      end
      state == RGHT: neg_ax = 1'b1;
      default: ;
    endcase
  end

  assign sum = base
             + (neg_ax  ? -ax : ax)
             + (neg_yaw ? -py : py);

  spd_sat u_sat (.sum(sum), .spd(sat));

  assign mot = work.cal ? CAL_SPD : sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      work         <= '0;
      sh_f         <= '0;
      sh_b         <= '0;
      sh_l         <= '0;
      sh_r         <= '0;
      mix.frnt_spd <= '0;
      mix.bck_spd  <= '0;
      mix.lft_spd  <= '0;
      mix.rght_spd <= '0;
      mix.spd_vld  <= 1'b0;
    end else begin
      state       <= nxt;
      mix.spd_vld <= 1'b0;
      unique case (state)
        IDLE: if (mix.vld_in) work <= in_t;
        FRNT: sh_f <= mot;
        BCK:  sh_b <= mot;
        LFT:  sh_l <= mot;
        RGHT: sh_r <= mot;
        DONE: begin
          mix.frnt_spd <= sh_f;
          mix.bck_spd  <= sh_b;
          mix.lft_spd  <= sh_l;
          mix.rght_spd <= sh_r;
          mix.spd_vld  <= 1'b1;
          if (pend_vld)        work <= pend;
          else if (mix.vld_in) work <= in_t;
        end
        default: ;
      endcase
    end
  end

  // In DONE the slot drains first, so a same-cycle update refills it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_vld   <= 1'b0;
      mix.ovrrun <= 1'b0;
    end else begin
      mix.ovrrun <= 1'b0;
      if (state == DONE) begin
        if (pend_vld) begin
          pend_vld <= mix.vld_in;
          if (mix.vld_in) pend <= in_t;
        end
      end else if (mix.busy && mix.vld_in) begin
        pend       <= in_t;
        pend_vld   <= 1'b1;
        mix.ovrrun <= pend_vld;
      end
    end
  end

endmodule
